intadd_issue: RTL and testbench
===============================

INTADD_ISSUE -- requirements
Module: intadd_issue

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: cmd_valid  input  1  command offered.
REQ-004 SHALL have port: cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-005 SHALL have port: cmd_precision  input  2  00 = 4b+8b mode, 11 = 32b mode, 01/10 = illegal.
REQ-006 SHALL have port: cmd_sign  input  3  signedness per source; bit n maps to sign_sn.
REQ-007 SHALL have port: cmd_src0, cmd_src1, cmd_src2  input  128 each  operands.
REQ-008 SHALL have port: add_src_reg0, add_src_reg1, add_src_reg2  output  128 each  to intadd src_reg0..2.
REQ-009 SHALL have port: add_precision_s0, add_precision_s1, add_precision_s2  output  2 each  to intadd.
REQ-010 SHALL have port: add_sign_s0, add_sign_s1, add_sign_s2  output  1 each  to intadd.
REQ-011 SHALL have port: add_inst_valid  output  1  to intadd inst_valid.
REQ-012 SHALL have port: add_dst_reg0, add_dst_reg1  input  128 each  from intadd dst_reg0/dst_reg1.
REQ-013 SHALL have port: rsp_valid  output  1  response available.
REQ-014 SHALL have port: rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-015 SHALL have port: rsp_dst0, rsp_dst1  output  128 each  captured results.
REQ-016 SHALL have port: rsp_err  output  1  illegal precision code in command.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, CAPTURE, RESP.
REQ-018 cmd_ready SHALL be high in IDLE only, combinationally from state.
REQ-019 IDLE: on cmd_valid, SHALL register precision, sign and operands; legal precision -> ISSUE, illegal -> RESP with rsp_err=1, rsp_dst0/1=0, no intadd activity.
REQ-020 4b+8b mode SHALL drive add_precision_s0..s2=00, all three operands, all three sign bits.
REQ-021 32b mode SHALL drive add_precision_s0/s1=11, add_precision_s2=00, add_src_reg2=0, add_sign_s2=0.
REQ-022 ISSUE SHALL last one cycle with add_inst_valid=1, then go to CAPTURE.
REQ-023 CAPTURE SHALL keep add_* operand outputs stable, drive add_inst_valid=1, register add_dst_reg0/1 into rsp_dst0/1 at cycle end, go to RESP.
REQ-024 Outside ISSUE/CAPTURE, add_inst_valid SHALL be 0 and all add_* data outputs 0.
REQ-025 RESP: rsp_valid=1; rsp_dst0/1/rsp_err SHALL stay stable until rsp_ready; on handshake -> IDLE.
REQ-026 Latency: cmd handshake in cycle N -> rsp_valid first high in cycle N+3.
REQ-027 SHALL not accept a new command before the response handshake completes (one in flight; cmd_ready=0 in RESP even if rsp_ready=1).
REQ-028 cmd_valid with X on unused fields (cmd_src2, cmd_sign[2] in 32b mode) SHALL not propagate X to add_* outputs.

Reset
REQ-029 rst SHALL force state IDLE on the next edge, overriding any in-flight command, which is dropped without response.
REQ-030 After reset: cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_dst0/1=0, add_inst_valid=0, all add_* outputs=0.

Configuration
REQ-031 Macro INTADD_ISSUE_PERF_EN SHALL, when defined, add output op_count (32 bits): count of completed response handshakes with rsp_err=0; cleared by rst; wraps 0xFFFFFFFF->0.
REQ-032 Without INTADD_ISSUE_PERF_EN, op_count port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-033 Reset: hold rst 2 cycles mid-CAPTURE -> IDLE, cmd_ready=1, rsp_valid=0, add_inst_valid=0, no response emitted.
REQ-034 4b+8b: precision=00, sign=000, src0 nibble0=0x2, src1=0xE, src2=0xF -> add_inst_valid high cycles N+1..N+2, rsp_valid at N+3, rsp_dst0/1 equal the intadd outputs for those operands.
REQ-035 32b: precision=11, sign=000, src0 lane0=0xFFFFFFFE, src1 lane0=0x2, src2=X -> add_src_reg2=0, add_precision_s2=00, response matches intadd.
REQ-036 Illegal: precision=01 -> add_inst_valid never high, rsp_valid at N+1, rsp_err=1, rsp_dst0/1=0.
REQ-037 Backpressure: rsp_ready low 5 cycles -> rsp_* stable, cmd_ready=0, second cmd_valid not accepted until the cycle after the handshake.
REQ-038 With INTADD_ISSUE_PERF_EN: 3 legal + 1 illegal command -> op_count=3.

Source files
------------

// File: rtl/intadd_issue_if.sv
// Command, response and intadd-side bus bundle for intadd_issue.
// master = requester/intadd side, slave = the issue block.
interface intadd_issue_if;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned PREC_W = 2;
  localparam int unsigned SIGN_W = 3;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [PREC_W-1:0] cmd_precision;
  logic [SIGN_W-1:0] cmd_sign;
  logic [DATA_W-1:0] cmd_src0;
  logic [DATA_W-1:0] cmd_src1;
  logic [DATA_W-1:0] cmd_src2;

  logic [DATA_W-1:0] add_src_reg0;
  logic [DATA_W-1:0] add_src_reg1;
  logic [DATA_W-1:0] add_src_reg2;
  logic [PREC_W-1:0] add_precision_s0;
  logic [PREC_W-1:0] add_precision_s1;
  logic [PREC_W-1:0] add_precision_s2;
  logic              add_sign_s0;
  logic              add_sign_s1;
  logic              add_sign_s2;
  logic              add_inst_valid;
  logic [DATA_W-1:0] add_dst_reg0;
  logic [DATA_W-1:0] add_dst_reg1;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_dst0;
  logic [DATA_W-1:0] rsp_dst1;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_precision, cmd_sign, cmd_src0, cmd_src1, cmd_src2,
    output add_dst_reg0, add_dst_reg1, rsp_ready,
    input  cmd_ready, add_src_reg0, add_src_reg1, add_src_reg2,
    input  add_precision_s0, add_precision_s1, add_precision_s2,
    input  add_sign_s0, add_sign_s1, add_sign_s2, add_inst_valid,
    input  rsp_valid, rsp_dst0, rsp_dst1, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_precision, cmd_sign, cmd_src0, cmd_src1, cmd_src2,
    input  add_dst_reg0, add_dst_reg1, rsp_ready,
    output cmd_ready, add_src_reg0, add_src_reg1, add_src_reg2,
    output add_precision_s0, add_precision_s1, add_precision_s2,
    output add_sign_s0, add_sign_s1, add_sign_s2, add_inst_valid,
    output rsp_valid, rsp_dst0, rsp_dst1, rsp_err
  );
endinterface

// File: rtl/intadd_issue.sv
// Single-outstanding issue/capture wrapper around the intadd datapath.
// Optional INTADD_ISSUE_PERF_EN adds op_count (successful response handshakes).
module intadd_issue (
  input  logic               clk,
  input  logic               rst,
  intadd_issue_if.slave      bus
`ifdef INTADD_ISSUE_PERF_EN
  ,
  output logic [31:0]        op_count
`endif
);
  localparam int unsigned DATA_W = 128;
  localparam int unsigned PREC_W = 2;
  localparam logic [PREC_W-1:0] PREC_MIX = 2'b00;
  localparam logic [PREC_W-1:0] PREC_32  = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t state;
  logic   prec_32;
  logic   prec_legal;

  assign bus.cmd_ready = (state == IDLE);
  assign prec_32       = (bus.cmd_precision == PREC_32);
  assign prec_legal    = prec_32 || (bus.cmd_precision == PREC_MIX);

  // Operands are loaded straight into the add_* registers on accept; in 32b
  // mode the third source slot is forced to zero so unused inputs never leak.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      bus.add_src_reg0     <= '0;
      bus.add_src_reg1     <= '0;
      bus.add_src_reg2     <= '0;
      bus.add_precision_s0 <= '0;
      bus.add_precision_s1 <= '0;
      bus.add_precision_s2 <= '0;
      bus.add_sign_s0      <= 1'b0;
      bus.add_sign_s1      <= 1'b0;
      bus.add_sign_s2      <= 1'b0;
      bus.add_inst_valid   <= 1'b0;
      bus.rsp_valid        <= 1'b0;
      bus.rsp_err          <= 1'b0;
      bus.rsp_dst0         <= '0;
      bus.rsp_dst1         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            if (prec_legal) begin
              state                <= ISSUE;
              bus.add_inst_valid   <= 1'b1;
              bus.add_src_reg0     <= bus.cmd_src0;
              bus.add_src_reg1     <= bus.cmd_src1;
              bus.add_src_reg2     <= prec_32 ? DATA_W'(0) : bus.cmd_src2;
              bus.add_precision_s0 <= prec_32 ? PREC_32 : PREC_MIX;
              bus.add_precision_s1 <= prec_32 ? PREC_32 : PREC_MIX;
              bus.add_precision_s2 <= PREC_MIX;
              bus.add_sign_s0      <= bus.cmd_sign[0];
              bus.add_sign_s1      <= bus.cmd_sign[1];
              bus.add_sign_s2      <= prec_32 ? 1'b0 : bus.cmd_sign[2];
            end else begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_dst0  <= '0;
              bus.rsp_dst1  <= '0;
            end
          end
        end
        ISSUE: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          state                <= RESP;
          bus.rsp_valid        <= 1'b1;
          bus.rsp_err          <= 1'b0;
          bus.rsp_dst0         <= bus.add_dst_reg0;
          bus.rsp_dst1         <= bus.add_dst_reg1;
          bus.add_inst_valid   <= 1'b0;
          bus.add_src_reg0     <= '0;
          bus.add_src_reg1     <= '0;
          bus.add_src_reg2     <= '0;
          bus.add_precision_s0 <= '0;
          bus.add_precision_s1 <= '0;
          bus.add_precision_s2 <= '0;
          bus.add_sign_s0      <= 1'b0;
          bus.add_sign_s1      <= 1'b0;
          bus.add_sign_s2      <= 1'b0;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef INTADD_ISSUE_PERF_EN
  // Counts only error-free responses; wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if ((state == RESP) && bus.rsp_ready && !bus.rsp_err) begin
      op_count <= op_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_intadd_issue.sv
// Scoreboard bench for intadd_issue: randomized commands, a registered intadd
// stand-in, and a monitor that checks intadd-side and response-side traffic.
module tb_intadd_issue;
  localparam int unsigned DW = 128;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  intadd_issue_if bus();
`ifdef INTADD_ISSUE_PERF_EN
  logic [31:0] op_count;
`endif

  intadd_issue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef INTADD_ISSUE_PERF_EN
    ,
    .op_count (op_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic          err;
    int            cyc;
  } rsp_t;

  rsp_t          sb[$];
  int            n_chk = 0;
  int            n_err = 0;
  int            act_cyc = 0;
  bit            act_valid = 1'b0;
  logic [DW-1:0] ea0, ea1, ea2;
  logic [8:0]    epg;
  int            last_hs = -10;
  int            exp_ops = 0;
  int            force_low = 0;
  bit            mon_en = 1'b0;
  bit            prev_v = 1'b0;
  logic [DW-1:0] prev_d0, prev_d1;
  logic          prev_e;

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Stand-in for intadd: deterministic mix of all inputs, one cycle latency.
  function automatic logic [2*DW-1:0] intadd_f(input logic [DW-1:0] a, b, c, input logic [8:0] pg);
    logic [DW-1:0] tag;
    tag = {119'd0, pg};
    return {((a + b + c) ^ tag), ((a ^ {b[63:0], b[127:64]}) - c - tag)};
  endfunction

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: got timeout expected completion (cycle %0d)", nm, cyc);
  endtask

  always @(posedge clk) begin
    logic [2*DW-1:0] r;
    if (bus.add_inst_valid)
      r = intadd_f(bus.add_src_reg0, bus.add_src_reg1, bus.add_src_reg2,
                   {bus.add_precision_s0, bus.add_precision_s1, bus.add_precision_s2,
                    bus.add_sign_s0, bus.add_sign_s1, bus.add_sign_s2});
    else
      r = {rnd128(), rnd128()};
    bus.add_dst_reg0 <= r[2*DW-1:DW];
    bus.add_dst_reg1 <= r[DW-1:0];
  end

  always @(posedge clk) begin
    #1;
    if (force_low > 0) begin
      bus.rsp_ready = 1'b0;
      if (bus.rsp_valid) force_low--;
    end else begin
      bus.rsp_ready = ($urandom % 3) != 0;
    end
  end

  // Monitor: intadd-side window, response latency/content/stability.
  always @(negedge clk) begin
    if (mon_en) begin
      bit   iv;
      rsp_t cur;
      iv = act_valid && ((cyc == act_cyc + 1) || (cyc == act_cyc + 2));
      chk("add_inst_valid", 256'(bus.add_inst_valid), 256'(iv));
      chk("add_src_reg0", 256'(bus.add_src_reg0), iv ? 256'(ea0) : 256'(0));
      chk("add_src_reg1", 256'(bus.add_src_reg1), iv ? 256'(ea1) : 256'(0));
      chk("add_src_reg2", 256'(bus.add_src_reg2), iv ? 256'(ea2) : 256'(0));
      chk("add_prec_sign",
          256'({bus.add_precision_s0, bus.add_precision_s1, bus.add_precision_s2,
                bus.add_sign_s0, bus.add_sign_s1, bus.add_sign_s2}),
          iv ? 256'(epg) : 256'(0));
      if (bus.rsp_valid) begin
        chk("cmd_ready_in_resp", 256'(bus.cmd_ready), 256'(0));
        if (!prev_v) begin
          if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
          end else begin
            cur = sb[0];
            chk("rsp_latency", 256'(cyc), 256'(cur.cyc));
            chk("rsp_dst0", 256'(bus.rsp_dst0), 256'(cur.d0));
            chk("rsp_dst1", 256'(bus.rsp_dst1), 256'(cur.d1));
            chk("rsp_err", 256'(bus.rsp_err), 256'(cur.err));
          end
        end else begin
          chk("hold_dst0", 256'(bus.rsp_dst0), 256'(prev_d0));
          chk("hold_dst1", 256'(bus.rsp_dst1), 256'(prev_d1));
          chk("hold_err", 256'(bus.rsp_err), 256'(prev_e));
        end
        if (bus.rsp_ready && sb.size() > 0) begin
          if (!sb[0].err) exp_ops++;
          void'(sb.pop_front());
          last_hs = cyc;
        end
      end
      prev_v  = bus.rsp_valid && !bus.rsp_ready;
      prev_d0 = bus.rsp_dst0;
      prev_d1 = bus.rsp_dst1;
      prev_e  = bus.rsp_err;
    end
  end

  task automatic send_cmd(input logic [1:0] p, input logic [2:0] s,
                          input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
    bit              acc;
    bit              outst;
    bit              legal;
    rsp_t            e;
    logic [2*DW-1:0] r;
    acc = 1'b0;
    @(posedge clk);
    #1;
    bus.cmd_precision = p;
    bus.cmd_sign      = s;
    bus.cmd_src0      = a;
    bus.cmd_src1      = b;
    bus.cmd_src2      = c;
    bus.cmd_valid     = 1'b1;
    outst = (sb.size() > 0);
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        acc = 1'b1;
        if (outst) chk("accept_after_rsp_hs", 256'(cyc), 256'(last_hs + 1));
        legal = (p == 2'b00) || (p == 2'b11);
        e.err = !legal;
        e.cyc = cyc + (legal ? 3 : 1);
        if (legal) begin
          ea0 = a;
          ea1 = b;
          if (p == 2'b11) begin
            ea2 = '0;
            epg = {2'b11, 2'b11, 2'b00, s[0], s[1], 1'b0};
          end else begin
            ea2 = c;
            epg = {6'b000000, s[0], s[1], s[2]};
          end
          r       = intadd_f(ea0, ea1, ea2, epg);
          e.d0    = r[2*DW-1:DW];
          e.d1    = r[DW-1:0];
          act_cyc = cyc;
          act_valid = 1'b1;
        end else begin
          e.d0 = '0;
          e.d1 = '0;
          act_valid = 1'b0;
        end
        sb.push_back(e);
      end
    end
    if (!acc) fail("cmd_accept_timeout");
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_src0  = rnd128();
    bus.cmd_src2  = rnd128();
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.rsp_valid) done = 1'b1;
    end
    if (!done) fail("drain_timeout");
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_cmd_ready"}, 256'(bus.cmd_ready), 256'(1));
    chk({tag, "_rsp_valid"}, 256'(bus.rsp_valid), 256'(0));
    chk({tag, "_rsp_err"}, 256'(bus.rsp_err), 256'(0));
    chk({tag, "_rsp_dst0"}, 256'(bus.rsp_dst0), 256'(0));
    chk({tag, "_rsp_dst1"}, 256'(bus.rsp_dst1), 256'(0));
    chk({tag, "_add_inst_valid"}, 256'(bus.add_inst_valid), 256'(0));
    chk({tag, "_add_src_reg0"}, 256'(bus.add_src_reg0), 256'(0));
  endtask

  initial begin
    logic [1:0]    p;
    logic [2:0]    s;
    logic [DW-1:0] c;
    int            r;
    rst               = 1'b1;
    bus.cmd_valid     = 1'b0;
    bus.cmd_precision = '0;
    bus.cmd_sign      = '0;
    bus.cmd_src0      = '0;
    bus.cmd_src1      = '0;
    bus.cmd_src2      = '0;
    bus.rsp_ready     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle("reset");
    mon_en = 1'b1;

    send_cmd(2'b00, 3'b000, 128'h2, 128'hE, 128'hF);
    send_cmd(2'b11, 3'b000, 128'hFFFF_FFFE, 128'h2, 'x);
    send_cmd(2'b01, 3'b111, rnd128(), rnd128(), rnd128());
    send_cmd(2'b10, 3'b010, rnd128(), rnd128(), rnd128());
    drain();

    // Backpressure with a second command queued behind the first.
    force_low = 5;
    send_cmd(2'b00, 3'b011, rnd128(), rnd128(), rnd128());
    send_cmd(2'b11, 3'b001, rnd128(), rnd128(), rnd128());
    drain();

    // Reset while the command sits in CAPTURE; it must vanish.
    send_cmd(2'b00, 3'b101, rnd128(), rnd128(), rnd128());
    @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    exp_ops = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle("midreset");

    send_cmd(2'b00, 3'b100, rnd128(), rnd128(), rnd128());
    send_cmd(2'b11, 3'b011, rnd128(), rnd128(), rnd128());
    send_cmd(2'b01, 3'b000, rnd128(), rnd128(), rnd128());
    send_cmd(2'b00, 3'b111, rnd128(), rnd128(), rnd128());

    for (int k = 0; k < 40; k++) begin
      r = int'($urandom % 8);
      if (r < 4)       p = 2'b00;
      else if (r < 7)  p = 2'b11;
      else             p = ($urandom % 2) ? 2'b01 : 2'b10;
      s = 3'($urandom);
      c = rnd128();
      if (p == 2'b11 && ($urandom % 2) == 1) begin
        c    = 'x;
        s[2] = 1'bx;
      end
      send_cmd(p, s, rnd128(), rnd128(), c);
      repeat ($urandom % 3) @(posedge clk);
    end
    drain();

`ifdef INTADD_ISSUE_PERF_EN
    @(posedge clk);
    @(negedge clk);
    chk("op_count", 256'(op_count), 256'(exp_ops));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
